// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_master_pkg;

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StGap} spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] Mode0 = 2'b00;
  localparam logic [1:0] Mode1 = 2'b01;
  localparam logic [1:0] Mode2 = 2'b10;
  localparam logic [1:0] Mode3 = 2'b11;

  // Cycles with SS asserted for one single-word frame
  function automatic int unsigned frame_cycles(input int unsigned data_w, input int unsigned div);
    return (2 * data_w + 2) * (div + 1);
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word fall-through FIFO; extra pointer MSB tells full from empty.
module spi_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, all CPOL/CPHA modes, bit order select and burst frames.
module spi_master_fifo
  import spi_master_pkg::*;
#(
  parameter int unsigned DataW     = 8,
  parameter int unsigned NumSs     = 8,
  parameter int unsigned FifoDepth = 8,
  parameter int unsigned DivW      = 8,
  localparam int unsigned SelW     = (NumSs > 1) ? $clog2(NumSs) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_cpol_i,
  input  logic             cfg_cpha_i,
  input  logic             cfg_lsb_first_i,
  input  logic             cfg_cont_i,
  input  logic [DivW-1:0]  cfg_div_i,
  input  logic [SelW-1:0]  cfg_ss_sel_i,
  input  logic [DataW-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [DataW-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             rx_ovf_o,
  input  logic             ovf_clr_i,
  output logic             busy_o,
  output logic             sclk_o,
  output logic             mosi_o,
  input  logic             miso_i,
  output logic [NumSs-1:0] ss_n_o
);

  localparam int unsigned EdgeW = $clog2(2 * DataW);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DataW - 1);

  spi_state_e       state_q, state_d;
  logic [DivW-1:0]  cnt_q, cnt_d, div_q;
  logic [EdgeW-1:0] edge_q, edge_d;
  logic             cpol_q, cpha_q, lsb_q, cont_q;
  logic [SelW-1:0]  sel_q;
  logic [DataW-1:0] tx_sr_q, tx_sr_d, rx_sr_q, tx_rdata;
  logic             mosi_q, mosi_d, sclk_q, sclk_d, miso_q, samp_q, ovf_q;
  logic             tx_empty, tx_full, rx_full, rx_empty, rx_push;
  logic             tick, cfg_load, load, ev, ev_lead, drive, sample, cpha_eff, lsb_eff;

  function automatic logic out_bit(input logic [DataW-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DataW-1];
  endfunction

  function automatic logic [DataW-1:0] shift_w(input logic [DataW-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign tick = (cnt_q == div_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    cfg_load = 1'b0;
    load     = 1'b0;
    ev       = 1'b0;
    ev_lead  = 1'b0;
    rx_push  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        sclk_d = cfg_cpol_i;
        if (!tx_empty) begin
          cfg_load = 1'b1;
          load     = 1'b1;
          state_d  = StSetup;
        end
      end
      StSetup: if (tick) begin
        state_d = StXfer;
        edge_d  = '0;
        ev      = 1'b1;
        ev_lead = 1'b1;
      end
      StXfer: if (tick) begin
        if (edge_q == LastEdge) begin
          state_d = StHold;
        end else begin
          edge_d  = edge_q + 1'b1;
          ev      = 1'b1;
          // Half-periods with even index start on a leading edge
          ev_lead = edge_q[0];
        end
      end
      StHold: begin
        rx_push = (cnt_q == '0);
        if (tick) begin
          if (cont_q && !tx_empty) begin
            load    = 1'b1;
            state_d = StSetup;
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (ev) sclk_d = cpol_q ^ ev_lead;
  end

  // In IDLE the frame config is not latched yet, so the live inputs decide the first bit
  assign cpha_eff = (state_q == StIdle) ? cfg_cpha_i : cpha_q;
  assign lsb_eff  = (state_q == StIdle) ? cfg_lsb_first_i : lsb_q;
  assign drive    = ev && (cpha_q ? ev_lead : !ev_lead);
  assign sample   = ev && (cpha_q ? !ev_lead : ev_lead);

  always_comb begin
    tx_sr_d = tx_sr_q;
    mosi_d  = mosi_q;
    if (load) begin
      if (!cpha_eff) begin
        mosi_d  = out_bit(tx_rdata, lsb_eff);
        tx_sr_d = shift_w(tx_rdata, lsb_eff);
      end else begin
        tx_sr_d = tx_rdata;
      end
    end else if (drive) begin
      mosi_d  = out_bit(tx_sr_q, lsb_q);
      tx_sr_d = shift_w(tx_sr_q, lsb_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      edge_q  <= '0;
      div_q   <= '0;
      sel_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      cont_q  <= 1'b0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      miso_q  <= 1'b0;
      samp_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      tx_sr_q <= tx_sr_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      miso_q  <= miso_i;
      // Capture one cycle after the sample edge so miso_q holds the bit present at that edge
      samp_q  <= sample;
      if (samp_q) begin
        rx_sr_q <= lsb_q ? {miso_q, rx_sr_q[DataW-1:1]} : {rx_sr_q[DataW-2:0], miso_q};
      end
      if (cfg_load) begin
        cpol_q <= cfg_cpol_i;
        cpha_q <= cfg_cpha_i;
        lsb_q  <= cfg_lsb_first_i;
        cont_q <= cfg_cont_i;
        div_q  <= cfg_div_i;
        sel_q  <= cfg_ss_sel_i;
      end
      if (rx_push && rx_full) ovf_q <= 1'b1;
      else if (ovf_clr_i)     ovf_q <= 1'b0;
    end
  end

  always_comb begin
    ss_n_o = '1;
    if ((state_q == StSetup || state_q == StXfer || state_q == StHold) &&
        (32'(sel_q) < NumSs)) begin
      ss_n_o[sel_q] = 1'b0;
    end
  end

  assign busy_o     = (state_q != StIdle) || !tx_empty;
  assign tx_ready_o = !tx_full;
  assign rx_valid_o = !rx_empty;
  assign rx_ovf_o   = ovf_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;

  spi_sync_fifo #(
    .Width (DataW),
    .Depth (FifoDepth)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_valid_i),
    .wdata_i (tx_data_i),
    .pop_i   (load),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  spi_sync_fifo #(
    .Width (DataW),
    .Depth (FifoDepth)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .wdata_i (rx_sr_q),
    .pop_i   (rx_ready_i),
    .rdata_o (rx_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: modes, bit order, bursts, overflow, reset abort, SS select.
module tb_spi_master_fifo;
  import spi_master_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_cont;
  logic [7:0] cfg_div;
  logic [2:0] cfg_ss_sel;
  logic [7:0] tx_data, rx_data, ss_n;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, rx_ovf, ovf_clr, busy;
  logic       sclk, mosi, miso, miso_ext, loop_en;

  int n_checks = 0;
  int n_pass   = 0;

  assign miso = loop_en ? mosi : miso_ext;

  always #5 clk = ~clk;

  spi_master_fifo #(
    .DataW     (8),
    .NumSs     (8),
    .FifoDepth (4),
    .DivW      (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_cpol_i      (cfg_cpol),
    .cfg_cpha_i      (cfg_cpha),
    .cfg_lsb_first_i (cfg_lsb_first),
    .cfg_cont_i      (cfg_cont),
    .cfg_div_i       (cfg_div),
    .cfg_ss_sel_i    (cfg_ss_sel),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready),
    .rx_data_o       (rx_data),
    .rx_valid_o      (rx_valid),
    .rx_ready_i      (rx_ready),
    .rx_ovf_o        (rx_ovf),
    .ovf_clr_i       (ovf_clr),
    .busy_o          (busy),
    .sclk_o          (sclk),
    .mosi_o          (mosi),
    .miso_i          (miso),
    .ss_n_o          (ss_n)
  );

  // Bus monitor plus a simple slave that shifts slv_pat out LSB-first on each sclk fall
  logic       mon_clr;
  int         ss_low_cnt, ss_fall_cnt, sclk_rise_cnt;
  logic [7:0] ss_low_val, mosi_lsb, mosi_msb, slv_pat, slv_sr;
  logic       sclk_prev, ss_low_prev;

  always @(posedge clk) begin
    sclk_prev   <= sclk;
    ss_low_prev <= (ss_n != 8'hFF);
    if (mon_clr) begin
      ss_low_cnt    <= 0;
      ss_fall_cnt   <= 0;
      sclk_rise_cnt <= 0;
      ss_low_val    <= 8'hFF;
      mosi_lsb      <= 8'h00;
      mosi_msb      <= 8'h00;
      slv_sr        <= slv_pat;
      miso_ext      <= 1'b0;
    end else begin
      if (ss_n != 8'hFF) begin
        ss_low_cnt <= ss_low_cnt + 1;
        ss_low_val <= ss_n;
        if (!ss_low_prev) ss_fall_cnt <= ss_fall_cnt + 1;
      end
      if (sclk && !sclk_prev) begin
        sclk_rise_cnt <= sclk_rise_cnt + 1;
        mosi_lsb      <= {mosi, mosi_lsb[7:1]};
        mosi_msb      <= {mosi_msb[6:0], mosi};
      end
      if (!sclk && sclk_prev) begin
        miso_ext <= slv_sr[0];
        slv_sr   <= slv_sr >> 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] w);
    for (int i = 0; i < 500 && !tx_ready; i++) step();
    if (!tx_ready) check_eq("push_timeout", 32'(tx_ready), 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 5000) begin
      step();
      i++;
    end
    if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
    step();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check_eq(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, 0 of 1 required");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ovf_words [5];
    ovf_words = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    rst = 1'b1;
    {cfg_cpol, cfg_cpha} = Mode0;
    cfg_lsb_first = 1'b0;
    cfg_cont      = 1'b0;
    cfg_div       = 8'd1;
    cfg_ss_sel    = 3'd0;
    tx_data       = 8'h00;
    tx_valid      = 1'b0;
    rx_ready      = 1'b0;
    ovf_clr       = 1'b0;
    loop_en       = 1'b1;
    slv_pat       = 8'h00;
    mon_clr       = 1'b0;
    clear_mon();
    repeat (3) step();

    // Reset state
    check_eq("rst_ss_n", 32'(ss_n), 32'hFF);
    check_eq("rst_sclk", 32'(sclk), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_ovf", 32'(rx_ovf), 32'd0);
    rst = 1'b0;
    step();
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);

    // Mode 0, div 1, loopback 0xA5
    clear_mon();
    push(8'hA5);
    wait_idle();
    check_eq("m0_ss_len", 32'(ss_low_cnt), 32'd36);
    check_eq("m0_ss_val", 32'(ss_low_val), 32'hFE);
    check_eq("m0_ss_falls", 32'(ss_fall_cnt), 32'd1);
    check_eq("m0_sclk_rises", 32'(sclk_rise_cnt), 32'd8);
    check_eq("m0_mosi_bits", 32'(mosi_msb), 32'hA5);
    check_eq("m0_rx_ovf", 32'(rx_ovf), 32'd0);
    pop_check("m0_rx", 8'hA5);

    // Mode 3, LSB first, slave returns 0x81
    {cfg_cpol, cfg_cpha} = Mode3;
    cfg_lsb_first = 1'b1;
    cfg_div       = 8'd2;
    loop_en       = 1'b0;
    slv_pat       = 8'h81;
    repeat (3) step();
    clear_mon();
    push(8'h3C);
    wait_idle();
    check_eq("m3_sclk_idle", 32'(sclk), 32'd1);
    check_eq("m3_mosi_bits", 32'(mosi_lsb), 32'h3C);
    check_eq("m3_sclk_rises", 32'(sclk_rise_cnt), 32'd8);
    check_eq("m3_ss_len", 32'(ss_low_cnt), 32'd54);
    pop_check("m3_rx", 8'h81);

    // Burst of three words, div 0
    {cfg_cpol, cfg_cpha} = Mode0;
    cfg_lsb_first = 1'b0;
    cfg_div       = 8'd0;
    cfg_cont      = 1'b1;
    loop_en       = 1'b1;
    repeat (3) step();
    clear_mon();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_idle();
    check_eq("burst_ss_len", 32'(ss_low_cnt), 32'd54);
    check_eq("burst_ss_falls", 32'(ss_fall_cnt), 32'd1);
    check_eq("burst_sclk_rises", 32'(sclk_rise_cnt), 32'd24);
    pop_check("burst_rx0", 8'h11);
    pop_check("burst_rx1", 8'h22);
    pop_check("burst_rx2", 8'h33);
    check_eq("burst_rx_empty", 32'(rx_valid), 32'd0);
    cfg_cont = 1'b0;

    // RX overflow: five words into a four-deep RX FIFO
    clear_mon();
    for (int i = 0; i < 5; i++) push(ovf_words[i]);
    wait_idle();
    check_eq("ovf_set", 32'(rx_ovf), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(rx_ovf), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("ovf_rx", ovf_words[i]);
    check_eq("ovf_rx_empty", 32'(rx_valid), 32'd0);

    // Reset during bit 4 of XFER, then a clean transfer
    cfg_div = 8'd1;
    repeat (2) step();
    clear_mon();
    push(8'hC3);
    repeat (19) step();
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    check_eq("abort_ss_before", 32'(ss_n), 32'hFE);
    rst = 1'b1;
    step();
    check_eq("abort_ss_n", 32'(ss_n), 32'hFF);
    check_eq("abort_sclk", 32'(sclk), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rx_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    step();
    check_eq("abort_tx_ready", 32'(tx_ready), 32'd1);
    clear_mon();
    push(8'h5A);
    wait_idle();
    check_eq("post_abort_ss_len", 32'(ss_low_cnt), 32'd36);
    pop_check("post_abort_rx", 8'h5A);

    // Slave 3, divider changed mid-frame takes effect on the next frame
    cfg_ss_sel = 3'd3;
    clear_mon();
    push(8'h96);
    repeat (5) step();
    cfg_div = 8'd3;
    wait_idle();
    check_eq("sel3_ss_val", 32'(ss_low_val), 32'hF7);
    check_eq("sel3_latched_len", 32'(ss_low_cnt), 32'd36);
    pop_check("sel3_rx0", 8'h96);
    clear_mon();
    push(8'h69);
    wait_idle();
    check_eq("sel3_new_div_len", 32'(ss_low_cnt), 32'd72);
    check_eq("sel3_ss_val2", 32'(ss_low_val), 32'hF7);
    pop_check("sel3_rx1", 8'h69);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
